// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among several byte-stream
// requesters. A grant is held until the requester marks a packet end or the burst
// limit is reached; each byte waits for a full busy rise/fall of the UART core.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int START_TMO = 512,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_wr_en,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 tmo_err
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           last_q, last_d;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     sel_data;

  // Index after i, wrapping NUM_REQ-1 back to 0 (NUM_REQ need not be a power of 2).
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  assign sel_data = req_data[{grant_q, 3'b000} +: 8];
  assign grant_id = grant_q;
  assign active   = (state_q != IDLE);

  // Round-robin search: first valid requester starting at rr_q.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDW'(cand);
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    last_d    = last_q;
    tx_wr_en  = 1'b0;
    req_ready = '0;
    tx_data   = '0;
    tmo_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[grant_q]) begin
          tx_wr_en           = 1'b1;
          req_ready[grant_q] = 1'b1;
          tx_data            = sel_data;
          last_d             = req_last[grant_q];
          burst_d            = burst_q + 1'b1;
          tmo_d              = '0;
          state_d            = WAIT_START;
        end else begin
          rr_d    = wrap_inc(grant_q);
          state_d = IDLE;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TMO - 1)) begin
          tmo_err = 1'b1;
          rr_d    = wrap_inc(grant_q);
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q || (burst_q == BW'(MAX_BURST))) begin
            rr_d    = wrap_inc(grant_q);
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a small UART busy model and requester sources.
module tb_uart_tx_sched;

  localparam int NR       = 4;
  localparam int BUSY_CYC = 4;

  logic          clk_50m, rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic [7:0]    tx_data;
  logic          tx_wr_en, tx_busy, active, tmo_err;
  logic [1:0]    grant_id;

  uart_tx_sched #(.NUM_REQ(NR), .MAX_BURST(16), .START_TMO(512)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .tmo_err   (tmo_err)
  );

  int         remaining[NR];
  int         sent[NR];
  int         pkt_len[NR];
  logic [7:0] base[NR];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         uart_on  = 1'b1;
  int         cyc      = 0;
  int         wr_id[$];
  logic [7:0] wr_data[$];
  logic [NR-1:0] wr_rdy[$];
  int         wr_cyc[$];

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = remaining[i] > 0;
      req_data[8*i +: 8] = base[i] + 8'(sent[i]);
      req_last[i]        = (pkt_len[i] > 0) && (((sent[i] + 1) % pkt_len[i]) == 0);
    end
  endtask

  initial begin
    clk_50m = 1'b0;
    forever #5 clk_50m = ~clk_50m;
  end

  // Records every write strobe and advances the granted source after the handshake edge.
  initial begin
    forever begin
      @(negedge clk_50m);
      cyc++;
      if (tx_wr_en === 1'b1) begin
        int g;
        g = int'(grant_id);
        wr_id.push_back(g);
        wr_data.push_back(tx_data);
        wr_rdy.push_back(req_ready);
        wr_cyc.push_back(cyc);
        @(posedge clk_50m);
        #1;
        sent[g]++;
        remaining[g]--;
        refresh();
      end
    end
  end

  // UART core stand-in: busy rises one cycle after the load and lasts BUSY_CYC cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (tx_wr_en === 1'b1 && uart_on) begin
        @(posedge clk_50m);
        #1 tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk_50m);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_done(input int budget, output bit ok);
    int tot;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50m);
      tot = 0;
      for (int r = 0; r < NR; r++) tot += remaining[r];
      if (!active && !tx_busy && tot == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 0; sent[i] = 0; pkt_len[i] = 1; base[i] = '0;
    end
    refresh();
    repeat (2) @(posedge clk_50m);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 1; sent[i] = 0; pkt_len[i] = 1; base[i] = 8'(8'h11 * (i + 1));
    end
    refresh();
    @(posedge clk_50m); #1;
    n_checks++; if (tx_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", tx_wr_en); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (tmo_err !== 1'b0) $display("FAIL reset_tmo got %b want 0", tmo_err); else n_pass++;
    @(posedge clk_50m); #1;
    n_checks++; if (active !== 1'b0) $display("FAIL reset_active got %b want 0", active); else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    int n0;
    do_reset();
    n0 = wr_id.size();
    base[0] = 8'h55; pkt_len[0] = 1; remaining[0] = 1;
    refresh();
    @(negedge clk_50m);
    n_checks++; if (tx_wr_en !== 1'b0) $display("FAIL single_cycle0_wr got %b want 0", tx_wr_en); else n_pass++;
    @(negedge clk_50m);
    n_checks++; if (tx_wr_en !== 1'b1) $display("FAIL single_cycle1_wr got %b want 1", tx_wr_en); else n_pass++;
    n_checks++; if (tx_data !== 8'h55) $display("FAIL single_data got %h want 55", tx_data); else n_pass++;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else n_pass++;
    wait_done(100, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_done got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_id.size() - n0 !== 1) $display("FAIL single_count got %0d want 1", wr_id.size() - n0); else n_pass++;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 1; pkt_len[i] = 1;
    end
    refresh();
    wait_done(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_probe_done got %b want 1", ok); else n_pass++;
    if (wr_id.size() > n0 + 1) begin
      n_checks++; if (wr_id[n0+1] !== 1) $display("FAIL single_rr_ptr got %0d want 1", wr_id[n0+1]); else n_pass++;
    end else begin
      n_checks++; $display("FAIL single_rr_ptr got no grant want 1");
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int n0;
    do_reset();
    n0 = wr_id.size();
    for (int i = 0; i < NR; i++) begin
      base[i] = 8'(16 * i + 1); pkt_len[i] = 1; remaining[i] = 2;
    end
    refresh();
    wait_done(300, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_done got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_id.size() - n0 !== 8) $display("FAIL rr_count got %0d want 8", wr_id.size() - n0); else n_pass++;
    if (wr_id.size() >= n0 + 8) begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wr_id[n0+k] !== k % 4) $display("FAIL rr_id[%0d] got %0d want %0d", k, wr_id[n0+k], k % 4);
        else n_pass++;
        n_checks++;
        if (wr_data[n0+k] !== 8'(16 * (k % 4) + 1 + k / 4))
          $display("FAIL rr_data[%0d] got %h want %h", k, wr_data[n0+k], 8'(16 * (k % 4) + 1 + k / 4));
        else n_pass++;
        n_checks++;
        if (wr_rdy[n0+k] !== 4'(1 << (k % 4)))
          $display("FAIL rr_ready[%0d] got %b want %b", k, wr_rdy[n0+k], 4'(1 << (k % 4)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    int n0;
    @(posedge clk_50m); #1;
    remaining[1] = 1; pkt_len[1] = 1;
    refresh();
    @(posedge clk_50m); #1;
    remaining[1] = 0;
    refresh();
    n0 = wr_id.size();
    @(negedge clk_50m);
    n_checks++; if (tx_wr_en !== 1'b0) $display("FAIL drop_wr got %b want 0", tx_wr_en); else n_pass++;
    n_checks++; if (grant_id !== 2'd1) $display("FAIL drop_grant got %0d want 1", grant_id); else n_pass++;
    n_checks++; if (active !== 1'b1) $display("FAIL drop_active_load got %b want 1", active); else n_pass++;
    @(negedge clk_50m);
    n_checks++; if (active !== 1'b0) $display("FAIL drop_idle got %b want 0", active); else n_pass++;
    n_checks++; if (wr_id.size() !== n0) $display("FAIL drop_no_write got %0d want %0d", wr_id.size(), n0); else n_pass++;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 1; pkt_len[i] = 1;
    end
    refresh();
    wait_done(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL drop_probe_done got %b want 1", ok); else n_pass++;
    if (wr_id.size() > n0) begin
      n_checks++; if (wr_id[n0] !== 2) $display("FAIL drop_rr_ptr got %0d want 2", wr_id[n0]); else n_pass++;
    end else begin
      n_checks++; $display("FAIL drop_rr_ptr got no grant want 2");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0, bad, exp_id;
    logic [7:0] exp_d;
    n0 = wr_id.size();
    sent[2] = 0; base[2] = 8'h40; pkt_len[2] = 20; remaining[2] = 20;
    sent[0] = 0; base[0] = 8'hA0; pkt_len[0] = 1;  remaining[0] = 1;
    refresh();
    wait_done(1000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL burst_done got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_id.size() - n0 !== 21) $display("FAIL burst_count got %0d want 21", wr_id.size() - n0); else n_pass++;
    if (wr_id.size() >= n0 + 21) begin
      for (int k = 0; k < 21; k++) begin
        exp_id = (k == 16) ? 0 : 2;
        exp_d  = (k < 16) ? 8'(8'h40 + k) : (k == 16) ? 8'hA0 : 8'(8'h40 + k - 1);
        n_checks++;
        if (wr_id[n0+k] !== exp_id) $display("FAIL burst_id[%0d] got %0d want %0d", k, wr_id[n0+k], exp_id);
        else n_pass++;
        n_checks++;
        if (wr_data[n0+k] !== exp_d) $display("FAIL burst_data[%0d] got %h want %h", k, wr_data[n0+k], exp_d);
        else n_pass++;
      end
      bad = 0;
      for (int k = 1; k < 16; k++)
        if (wr_cyc[n0+k] - wr_cyc[n0+k-1] != BUSY_CYC + 2) bad++;
      n_checks++; if (bad !== 0) $display("FAIL burst_spacing got %0d bad gaps want 0", bad); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int k;
    uart_on = 1'b0;
    @(posedge clk_50m); #1;
    sent[3] = 0; base[3] = 8'hC3; pkt_len[3] = 1; remaining[3] = 1;
    refresh();
    @(negedge clk_50m);
    @(negedge clk_50m);
    n_checks++; if (tx_wr_en !== 1'b1) $display("FAIL tmo_load_wr got %b want 1", tx_wr_en); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL tmo_grant got %0d want 3", grant_id); else n_pass++;
    k = 0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk_50m);
      if (tmo_err === 1'b1) begin
        k = i;
        break;
      end
    end
    n_checks++; if (k !== 512) $display("FAIL tmo_delay got %0d want 512", k); else n_pass++;
    @(negedge clk_50m);
    n_checks++; if (active !== 1'b0) $display("FAIL tmo_active got %b want 0", active); else n_pass++;
    n_checks++; if (tmo_err !== 1'b0) $display("FAIL tmo_pulse_width got %b want 0", tmo_err); else n_pass++;
    uart_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    @(posedge clk_50m); #1;
    sent[2] = 0; base[2] = 8'h77; pkt_len[2] = 1; remaining[2] = 1;
    refresh();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_50m); #2;
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL rstmid_busy got %b want 1", ok); else n_pass++;
    @(posedge clk_50m); #1;
    n_checks++; if (grant_id !== 2'd2) $display("FAIL rstmid_pre_grant got %0d want 2", grant_id); else n_pass++;
    rst = 1'b1;
    @(posedge clk_50m); #1;
    n_checks++; if (active !== 1'b0) $display("FAIL rstmid_active got %b want 0", active); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL rstmid_grant got %0d want 0", grant_id); else n_pass++;
    n_checks++;
    if ({tx_wr_en, tmo_err, req_ready, tx_data} !== 14'd0)
      $display("FAIL rstmid_outputs got %h want 0", {tx_wr_en, tmo_err, req_ready, tx_data});
    else n_pass++;
    rst = 1'b0;
    wait_done(100, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rstmid_settle got %b want 1", ok); else n_pass++;
    n0 = wr_id.size();
    remaining[1] = 1; remaining[3] = 1;
    refresh();
    wait_done(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rstmid_probe_done got %b want 1", ok); else n_pass++;
    if (wr_id.size() > n0) begin
      n_checks++; if (wr_id[n0] !== 1) $display("FAIL rstmid_rr_ptr got %0d want 1", wr_id[n0]); else n_pass++;
    end else begin
      n_checks++; $display("FAIL rstmid_rr_ptr got no grant want 1");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
